counter_read_latch: RTL and testbench

COUNTER_READ_LATCH -- requirements
Module: counter_read_latch

---
 rtl/counter_read_latch.sv | 111 +++++++++++
 tb/tb_counter_read_latch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_read_latch.sv
// Read-side latch logic for one counter: count latch, optional status latch, LSB/MSB byte sequencing.
// Define STATUS_LATCH_READ_EN to build the read-back status latch; without it status commands are ignored.
module counter_read_latch (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic [15:0] CountIn,
    input  logic [5:0]  Mode,
    input  logic        OutPin,
    input  logic        NullCount,
    input  logic        CwWrite,
    input  logic        LatchCmd,
    input  logic        StatusLatchCmd,
    input  logic        RdStrobe,
    output logic [7:0]  DataOut,
    output logic        CountLatched,
    output logic        StatusLatched
);

    logic [15:0] ol;
    logic        count_latched;
    logic        byte_ptr;
    logic [1:0]  rw;
    logic [15:0] source;

    assign rw           = Mode[5:4];
    assign source       = count_latched ? ol : CountIn;
    assign CountLatched = count_latched;

`ifdef STATUS_LATCH_READ_EN
    logic [7:0] sl;
    logic       status_latched;

    assign StatusLatched = status_latched;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            sl             <= 8'h00;
            status_latched <= 1'b0;
        end else if (CwWrite) begin
            status_latched <= 1'b0;
        end else begin
            // A read while status is held consumes the status byte only.
            if (RdStrobe && status_latched) begin
                status_latched <= 1'b0;
            end
            if (StatusLatchCmd && !status_latched) begin
                sl             <= {OutPin, NullCount, Mode};
                status_latched <= 1'b1;
            end
        end
    end
`else
    logic status_latched;
    logic unused_status;

    assign status_latched = 1'b0;
    assign StatusLatched  = 1'b0;
    assign unused_status  = ^{StatusLatchCmd, OutPin, NullCount, Mode[3:0]};
`endif

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            ol            <= 16'h0000;
            count_latched <= 1'b0;
            byte_ptr      <= 1'b0;
        end else if (CwWrite) begin
            count_latched <= 1'b0;
            byte_ptr      <= 1'b0;
        end else begin
            if (RdStrobe && !status_latched) begin
                case (rw)
                    2'b01, 2'b10: begin
                        count_latched <= 1'b0;
                        byte_ptr      <= 1'b0;
                    end
                    2'b11: begin
                        byte_ptr <= ~byte_ptr;
                        if (byte_ptr) begin
                            count_latched <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            // Latch decision uses the pre-edge flag, so it wins over a same-cycle read clear.
            if (LatchCmd && !count_latched) begin
                ol            <= CountIn;
                count_latched <= 1'b1;
            end
        end
    end

    always_comb begin
        DataOut = 8'h00;
`ifdef STATUS_LATCH_READ_EN
        if (status_latched) begin
            DataOut = sl;
        end else begin
`else
        begin
`endif
            case (rw)
                2'b01:   DataOut = source[7:0];
                2'b10:   DataOut = source[15:8];
                2'b11:   DataOut = byte_ptr ? source[15:8] : source[7:0];
                default: DataOut = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_read_latch.sv
// Self-checking bench for counter_read_latch: directed scenarios with literal results plus random traffic
// compared every cycle against a reference model. Honours STATUS_LATCH_READ_EN like the design.
module tb_counter_read_latch;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic [15:0] CountIn = 16'h0000;
    logic [5:0]  Mode = 6'h00;
    logic        OutPin = 1'b0;
    logic        NullCount = 1'b0;
    logic        CwWrite = 1'b0;
    logic        LatchCmd = 1'b0;
    logic        StatusLatchCmd = 1'b0;
    logic        RdStrobe = 1'b0;
    logic [7:0]  DataOut;
    logic        CountLatched;
    logic        StatusLatched;

    int n_checks = 0;
    int n_fail   = 0;

    counter_read_latch dut (
        .Clock(Clock), .ResetN(ResetN), .CountIn(CountIn), .Mode(Mode),
        .OutPin(OutPin), .NullCount(NullCount), .CwWrite(CwWrite),
        .LatchCmd(LatchCmd), .StatusLatchCmd(StatusLatchCmd), .RdStrobe(RdStrobe),
        .DataOut(DataOut), .CountLatched(CountLatched), .StatusLatched(StatusLatched)
    );

    always #5 Clock = ~Clock;

    // Reference: a held count snapshot (or none), a held status byte (or none),
    // and which half of a two-byte read comes next.
    logic [15:0] held_count;
    bit          has_count;
    logic [7:0]  held_status;
    bit          has_status;
    bit          msb_next;

    function automatic logic [7:0] model_byte();
        logic [15:0] v;
        if (has_status) return held_status;
        v = has_count ? held_count : CountIn;
        case (Mode[5:4])
            2'b01:   return v[7:0];
            2'b10:   return v[15:8];
            2'b11:   return msb_next ? v[15:8] : v[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            held_count = 16'h0; has_count = 0;
            held_status = 8'h0; has_status = 0; msb_next = 0;
        end else if (CwWrite) begin
            has_count = 0; has_status = 0; msb_next = 0;
        end else begin
            bit had_count, had_status;
            had_count  = has_count;
            had_status = has_status;
            if (RdStrobe) begin
                if (had_status) has_status = 0;
                else if (Mode[5:4] == 2'b01 || Mode[5:4] == 2'b10) begin
                    has_count = 0; msb_next = 0;
                end else if (Mode[5:4] == 2'b11) begin
                    if (msb_next) has_count = 0;
                    msb_next = !msb_next;
                end
            end
            if (LatchCmd && !had_count) begin
                held_count = CountIn; has_count = 1;
            end
`ifdef STATUS_LATCH_READ_EN
            if (StatusLatchCmd && !had_status) begin
                held_status = {OutPin, NullCount, Mode}; has_status = 1;
            end
`endif
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge Clock) begin
        check("model_dataout", {8'h00, DataOut}, {8'h00, model_byte()});
        check("model_count_latched", {15'h0, CountLatched}, {15'h0, has_count});
        check("model_status_latched", {15'h0, StatusLatched}, {15'h0, has_status});
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_latch();
        LatchCmd = 1'b1; step(); LatchCmd = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [7:0] exp);
        RdStrobe = 1'b1;
        @(negedge Clock);
        check(name, {8'h00, DataOut}, {8'h00, exp});
        step();
        RdStrobe = 1'b0;
    endtask

    task automatic do_cw(input logic [5:0] m);
        Mode = m; CwWrite = 1'b1; step(); CwWrite = 1'b0;
    endtask

    logic [7:0] exp_b;

    initial begin
        Mode = 6'b000000;
        #3;
        @(negedge Clock);
        check("reset_dataout", {8'h00, DataOut}, 16'h0000);
        check("reset_count_latched", {15'h0, CountLatched}, 16'h0);
        check("reset_status_latched", {15'h0, StatusLatched}, 16'h0);
        step();
        ResetN = 1'b1;
        step();

        // Latched two-byte read ignores later count changes.
        do_cw(6'b110100);
        CountIn = 16'h1234; pulse_latch();
        CountIn = 16'h5678;
        do_read("rw11_latched_lsb", 8'h34);
        do_read("rw11_latched_msb", 8'h12);
        @(negedge Clock);
        check("rw11_latch_released", {15'h0, CountLatched}, 16'h0);
        step();

        // Second latch while held is ignored.
        CountIn = 16'hABCD; pulse_latch();
        CountIn = 16'h0001; pulse_latch();
        do_read("relatch_lsb", 8'hCD);
        do_read("relatch_msb", 8'hAB);

        // Status and count latched together.
        Mode = 6'b110100; OutPin = 1'b1; NullCount = 1'b0; CountIn = 16'h00FF;
        StatusLatchCmd = 1'b1; LatchCmd = 1'b1; step();
        StatusLatchCmd = 1'b0; LatchCmd = 1'b0;
`ifdef STATUS_LATCH_READ_EN
        do_read("status_byte", 8'hB4);
        do_read("status_then_lsb", 8'hFF);
        do_read("status_then_msb", 8'h00);
`else
        do_read("nostatus_lsb", 8'hFF);
        do_read("nostatus_msb", 8'h00);
        do_read("nostatus_lsb_again", 8'hFF);
`endif

        // Control word write restarts the byte sequence.
        CountIn = 16'h7777;
        do_read("pre_cw_lsb", 8'h77);
        do_cw(6'b110100);
        CountIn = 16'h9A10;
        do_read("post_cw_lsb", 8'h10);
        do_read("post_cw_msb", 8'h9A);

        // Reset discards a held latch.
        do_cw(6'b100100);
        CountIn = 16'h4321; pulse_latch();
        ResetN = 1'b0; #2;
        check("async_reset_clears", {15'h0, CountLatched}, 16'h0);
        step();
        ResetN = 1'b1;
        CountIn = 16'h1111;
        do_read("after_reset_msb", 8'h11);

        // Status command with RW=01.
        do_cw(6'b010100);
        OutPin = 1'b0; NullCount = 1'b1; CountIn = 16'h0042;
        StatusLatchCmd = 1'b1; step(); StatusLatchCmd = 1'b0;
`ifdef STATUS_LATCH_READ_EN
        exp_b = {1'b0, 1'b1, 6'b010100};
`else
        exp_b = 8'h42;
`endif
        do_read("status_cmd_rw01", exp_b);
        do_read("rw01_live", 8'h42);

        // Random traffic checked only by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            CountIn        = 16'($urandom);
            OutPin         = 1'($urandom);
            NullCount      = 1'($urandom);
            CwWrite        = ($urandom_range(0, 15) == 0);
            if (CwWrite || $urandom_range(0, 31) == 0) Mode = 6'($urandom);
            LatchCmd       = ($urandom_range(0, 3) == 0);
            StatusLatchCmd = ($urandom_range(0, 4) == 0);
            RdStrobe       = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 199) == 0) begin
                ResetN = 1'b0; #2; ResetN = 1'b1;
            end
            step();
        end
        CwWrite = 0; LatchCmd = 0; StatusLatchCmd = 0; RdStrobe = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
